window_scan_ctrl: RTL and testbench
===================================

# window_scan_ctrl

Raster-scan controller that sequences the 3x3 RGB window datapath for one frame at a time. It accepts a pixel stream with a valid/ready handshake and keeps row/column counters. It drives the line-buffer write strobe and address, and presents `buf_valid` / `in_row2_cond` to the window extractor, stalling upstream whenever the convolution stage deasserts ready. It sits between the pixel source and the line buffer + window extractor, and reports frame completion to the top-level sequencer.

## Interface
- `WIDTH`, 32, image width in pixels (>= KERNEL_SIZE)
- `HEIGHT`, 32, image height in pixels (>= KERNEL_SIZE)
- `KERNEL_SIZE`, 3, window edge; first valid window at row = col = KERNEL_SIZE-1
- `clk`  in  1  clock
- `rstb`  in  1  reset, asynchronous, active-low
- `start`  in  1  frame start request; honoured only in IDLE
- `pix_valid`  in  1  upstream pixel valid
- `pix_ready`  out  1  upstream pixel ready
- `win_ready`  in  1  extractor/convolution ready (extractor `win_ready`)
- `buf_wr_en`  out  1  line-buffer write strobe, one cycle per accepted pixel
- `buf_col`  out  $clog2(WIDTH)  column of the pixel being written
- `buf_row`  out  $clog2(HEIGHT)  row of the pixel being written
- `buf_valid`  out  1  window data valid to extractor
- `in_row2_cond`  out  1  current window is a full in-image window
- `busy`  out  1  high in FILL or RUN
- `frame_done`  out  1  one-cycle pulse after the last window is handed off

## Operation
- States: IDLE, FILL, RUN, DONE. Reset -> IDLE.
- IDLE: `start`=1 -> FILL, with row and col cleared. `start` in any other state is ignored.
- FILL: rows 0..KERNEL_SIZE-2. Pixels are accepted and written; no window is qualified. The accept of (row KERNEL_SIZE-2, col WIDTH-1) -> RUN.
- RUN: the accept of (row HEIGHT-1, col WIDTH-1) -> DONE, but only once that pixel's `buf_valid` has been consumed (`win_ready`=1). Until then the FSM stays in RUN with `pix_ready`=0.
- DONE: pulses `frame_done` for one cycle, then -> IDLE.
- Accept = `pix_valid && pix_ready`.
  - `pix_ready` = (FILL or RUN) && (!`buf_valid` || `win_ready`) && not holding the last pixel.
- Column counter: increments on accept. It wraps WIDTH-1 -> 0, and the row counter increments on that wrap. There is no row wrap inside a frame.
- Output stage, per accept:
  - `buf_wr_en`=1, `buf_col`/`buf_row` = coordinates of that pixel, `buf_valid`=1.
  - `in_row2_cond` = (row >= KERNEL_SIZE-1 && col >= KERNEL_SIZE-1).
- `buf_valid` hold: it stays high, with `in_row2_cond` stable, until a cycle with `win_ready`=1. It then clears unless a new accept occurs in that same cycle (back-to-back streaming).
- Windows per frame = (WIDTH-KERNEL_SIZE+1)*(HEIGHT-KERNEL_SIZE+1). This is 900 for the defaults.

## Timing
- Reset values: `pix_ready`=0, `buf_wr_en`=0, `buf_col`=0, `buf_row`=0, `buf_valid`=0, `in_row2_cond`=0, `busy`=0, `frame_done`=0. All counters are 0.
- `start` at cycle N -> `busy`=1 and `pix_ready` may be 1 at N+1.
- Accept at cycle N -> `buf_wr_en`, `buf_col`, `buf_row`, `buf_valid` and `in_row2_cond` are all registered and valid at N+1. `buf_wr_en` is high for exactly that one cycle.
- With `pix_valid`=1 and `win_ready`=1 continuously, one pixel is accepted per cycle with no bubbles.
- `win_ready` low -> `pix_ready` low in the same cycle (combinational). Counters and outputs hold.
- Last window consumed at cycle M -> DONE and `frame_done`=1 at M+1, IDLE at M+2. `busy` drops at M+1.
- `start` is accepted again from the first cycle in IDLE.
- `rstb` low mid-frame -> immediate IDLE with all outputs at reset values. A partially scanned frame is discarded.

## Configuration
- `WSC_WIN_CNT_EN` defined:
  - Adds output `win_cnt`, 16 bits, counting `buf_valid && in_row2_cond && win_ready` handoffs in the current frame.
  - `win_cnt` is cleared on accepted `start` and on reset, and holds its final value through DONE/IDLE.
- `WSC_WIN_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- Defaults, continuous stream after `start` -> 1024 `buf_wr_en` pulses, 900 cycles with `buf_valid`&&`in_row2_cond`, first at (`buf_row`=2, `buf_col`=2). `frame_done` 1 cycle after the last window is consumed, `win_cnt`=900.
- WIDTH=4, HEIGHT=4 -> exactly 4 qualified windows, at (2,2), (2,3), (3,2), (3,3). `frame_done` 2 cycles after the final accept.
- `win_ready` forced low for 5 cycles mid-row at col 10 -> `pix_ready`=0 those cycles. `buf_valid` and `buf_col`=10 are held, no counter advance, and streaming resumes with col 11.
- `start` pulsed during RUN -> no effect on counters or state. `start` pulsed in the cycle after `frame_done` -> new frame begins with row=col=0.
- `rstb` asserted at row 5, col 7 -> all outputs 0 and state IDLE. A subsequent `start` runs a full 900-window frame.
- `pix_valid` toggled every other cycle -> one accept per high cycle, window count still 900, `buf_wr_en` never high two cycles for one pixel.

Source files
------------

// File: rtl/window_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_scan_ctrl_if : pixel handshake + line-buffer/extractor strobes      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface window_scan_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
) ();
    logic                      pix_valid;
    logic                      pix_ready;
    logic                      win_ready;
    logic                      buf_wr_en;
    logic [$clog2(WIDTH)-1:0]  buf_col;
    logic [$clog2(HEIGHT)-1:0] buf_row;
    logic                      buf_valid;
    logic                      in_row2_cond;

    modport master (
        input  pix_valid, win_ready,
        output pix_ready, buf_wr_en, buf_col, buf_row, buf_valid, in_row2_cond
    );

    modport slave (
        output pix_valid, win_ready,
        input  pix_ready, buf_wr_en, buf_col, buf_row, buf_valid, in_row2_cond
    );
endinterface
`default_nettype wire

// File: rtl/window_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | window_scan_ctrl : raster-scan sequencer for the 3x3 window datapath       |
// | Optional WSC_WIN_CNT_EN adds the win_cnt handoff counter. Revision: 1.0    |
// +----------------------------------------------------------------------------+
module window_scan_ctrl #(
    parameter int WIDTH       = 32,
    parameter int HEIGHT      = 32,
    parameter int KERNEL_SIZE = 3
) (
    input  wire logic           clk,
    input  wire logic           rstb,
    input  wire logic           start,
    window_scan_ctrl_if.master  bus,
    output logic                busy,
    output logic                frame_done
`ifdef WSC_WIN_CNT_EN
    ,
    output logic [15:0]         win_cnt
`endif
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FILL_LAST = ROW_W'(KERNEL_SIZE - 2);
    localparam logic [COL_W-1:0] COL_K         = COL_W'(KERNEL_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_K         = ROW_W'(KERNEL_SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             last_q, last_d;
    logic             buf_wr_en_q, buf_wr_en_d;
    logic [COL_W-1:0] buf_col_q, buf_col_d;
    logic [ROW_W-1:0] buf_row_q, buf_row_d;
    logic             buf_valid_q, buf_valid_d;
    logic             in_row2_cond_q, in_row2_cond_d;

    logic             scanning;
    logic             pix_ready;
    logic             accept;
    logic             pix_last;

    assign scanning  = (state_q == ST_FILL) || (state_q == ST_RUN);
    // last_q blocks new pixels while the final window waits for the extractor
    assign pix_ready = scanning && !last_q && (!buf_valid_q || bus.win_ready);
    assign accept    = bus.pix_valid && pix_ready;
    assign pix_last  = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        last_d         = last_q;
        buf_wr_en_d    = 1'b0;
        buf_col_d      = buf_col_q;
        buf_row_d      = buf_row_q;
        buf_valid_d    = buf_valid_q;
        in_row2_cond_d = in_row2_cond_q;

        if (bus.win_ready) begin
            buf_valid_d = 1'b0;
        end

        if (accept) begin
            buf_wr_en_d    = 1'b1;
            buf_col_d      = col_q;
            buf_row_d      = row_q;
            buf_valid_d    = 1'b1;
            in_row2_cond_d = (row_q >= ROW_K) && (col_q >= COL_K);
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (!pix_last) begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    col_d   = '0;
                    row_d   = '0;
                    last_d  = 1'b0;
                end
            end
            ST_FILL: begin
                if (accept && (row_q == ROW_FILL_LAST) && (col_q == COL_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && pix_last) begin
                    last_d = 1'b1;
                end
                if (last_q && buf_valid_q && bus.win_ready) begin
                    state_d = ST_DONE;
                    last_d  = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= ST_IDLE;
            col_q          <= '0;
            row_q          <= '0;
            last_q         <= 1'b0;
            buf_wr_en_q    <= 1'b0;
            buf_col_q      <= '0;
            buf_row_q      <= '0;
            buf_valid_q    <= 1'b0;
            in_row2_cond_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            last_q         <= last_d;
            buf_wr_en_q    <= buf_wr_en_d;
            buf_col_q      <= buf_col_d;
            buf_row_q      <= buf_row_d;
            buf_valid_q    <= buf_valid_d;
            in_row2_cond_q <= in_row2_cond_d;
        end
    end

`ifdef WSC_WIN_CNT_EN
    logic [15:0] win_cnt_q, win_cnt_d;

    always_comb begin
        win_cnt_d = win_cnt_q;
        if ((state_q == ST_IDLE) && start) begin
            win_cnt_d = '0;
        end else if (buf_valid_q && in_row2_cond_q && bus.win_ready) begin
            win_cnt_d = win_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

    assign win_cnt = win_cnt_q;
`endif

    assign bus.pix_ready    = pix_ready;
    assign bus.buf_wr_en    = buf_wr_en_q;
    assign bus.buf_col      = buf_col_q;
    assign bus.buf_row      = buf_row_q;
    assign bus.buf_valid    = buf_valid_q;
    assign bus.in_row2_cond = in_row2_cond_q;
    assign busy             = scanning;
    assign frame_done       = (state_q == ST_DONE);
endmodule
`default_nettype wire

// File: tb/tb_window_scan_ctrl.sv
`default_nettype none
// Bench for window_scan_ctrl: pixel-index reference model checked every cycle,
// plus directed frames (stream, stall, toggled valid, mid-frame reset, 4x4).
module tb_window_scan_ctrl;
    localparam int W   = 32;
    localparam int H   = 32;
    localparam int K   = 3;
    localparam int TOT = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstb, start, s_start;
    logic busy, frame_done, s_busy, s_frame_done;
`ifdef WSC_WIN_CNT_EN
    logic [15:0] win_cnt, s_win_cnt;
`endif

    window_scan_ctrl_if #(.WIDTH(W), .HEIGHT(H)) b  ();
    window_scan_ctrl_if #(.WIDTH(4), .HEIGHT(4)) sb ();

    window_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(K)) dut (
        .clk(clk), .rstb(rstb), .start(start), .bus(b),
        .busy(busy), .frame_done(frame_done)
`ifdef WSC_WIN_CNT_EN
        , .win_cnt(win_cnt)
`endif
    );

    window_scan_ctrl #(.WIDTH(4), .HEIGHT(4), .KERNEL_SIZE(K)) dut_s (
        .clk(clk), .rstb(rstb), .start(s_start), .bus(sb),
        .busy(s_busy), .frame_done(s_frame_done)
`ifdef WSC_WIN_CNT_EN
        , .win_cnt(s_win_cnt)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit qual(input int idx, input int w);
        return ((idx / w) >= K - 1) && ((idx % w) >= K - 1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: tracks pixels accepted, the pending window and frame phase
    logic m_active = 1'b0, m_done = 1'b0, m_pend = 1'b0, m_wr = 1'b0;
    int   m_n = 0, m_idx = 0, m_wins = 0;
    wire  m_rdy  = m_active && (m_n < TOT) && (!m_pend || b.win_ready);
    wire  m_acc  = m_rdy && b.pix_valid;
    wire  m_fin  = m_active && (m_n == TOT) && m_pend && b.win_ready;
    wire  m_idle = !m_active && !m_done;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_active <= 1'b0; m_done <= 1'b0; m_pend <= 1'b0; m_wr <= 1'b0;
            m_n <= 0; m_idx <= 0; m_wins <= 0;
        end else begin
            if (m_pend && b.win_ready && qual(m_idx, W)) m_wins <= m_wins + 1;
            if (m_acc) begin
                m_idx <= m_n; m_n <= m_n + 1; m_pend <= 1'b1; m_wr <= 1'b1;
            end else begin
                m_wr <= 1'b0;
                if (b.win_ready) m_pend <= 1'b0;
            end
            m_done <= m_fin;
            if (m_fin) m_active <= 1'b0;
            else if (m_idle && start) begin
                m_active <= 1'b1; m_n <= 0; m_wins <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("pix_ready",    32'(b.pix_ready),    32'(m_rdy));
        check("buf_wr_en",    32'(b.buf_wr_en),    32'(m_wr));
        check("buf_valid",    32'(b.buf_valid),    32'(m_pend));
        check("buf_row",      32'(b.buf_row),      m_idx / W);
        check("buf_col",      32'(b.buf_col),      m_idx % W);
        check("in_row2_cond", 32'(b.in_row2_cond), 32'(qual(m_idx, W)));
        check("busy",         32'(busy),           32'(m_active));
        check("frame_done",   32'(frame_done),     32'(m_done));
`ifdef WSC_WIN_CNT_EN
        check("win_cnt",      32'(win_cnt),        m_wins);
`endif
    end

    // Per-frame observations on the main instance
    int f_wr, f_win, f_done, f_dup, f_done_cyc, f_lastwin_cyc;
    int f_wr_r0, f_wr_c0, f_win_r0, f_win_c0, p_r, p_c;
    logic p_wr = 1'b0;

    always @(negedge clk) begin
        if (b.buf_wr_en) begin
            if (f_wr == 0) begin f_wr_r0 = 32'(b.buf_row); f_wr_c0 = 32'(b.buf_col); end
            if (p_wr && p_r == 32'(b.buf_row) && p_c == 32'(b.buf_col)) f_dup = f_dup + 1;
            f_wr = f_wr + 1;
        end
        p_wr = b.buf_wr_en; p_r = 32'(b.buf_row); p_c = 32'(b.buf_col);
        if (b.buf_valid && b.in_row2_cond && b.win_ready) begin
            if (f_win == 0) begin f_win_r0 = 32'(b.buf_row); f_win_c0 = 32'(b.buf_col); end
            f_win = f_win + 1;
            f_lastwin_cyc = cyc;
        end
        if (frame_done) begin f_done = f_done + 1; f_done_cyc = cyc; end
    end

    // 4x4 instance observations
    int s_acc = 0, s_wr = 0, s_nw = 0, s_done = 0, s_last_cyc = 0, s_done_cyc = 0;
    int s_r[8], s_c[8];

    always @(negedge clk) begin
        if (sb.pix_valid && sb.pix_ready) begin
            s_acc = s_acc + 1;
            if (s_acc == 16) s_last_cyc = cyc;
        end
        if (sb.buf_wr_en) s_wr = s_wr + 1;
        if (sb.buf_valid && sb.in_row2_cond && sb.win_ready) begin
            if (s_nw < 8) begin s_r[s_nw] = 32'(sb.buf_row); s_c[s_nw] = 32'(sb.buf_col); end
            s_nw = s_nw + 1;
        end
        if (s_frame_done) begin s_done = s_done + 1; s_done_cyc = cyc; end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_ready"},    32'(b.pix_ready),    0);
        check({tag, "_buf_wr_en"},    32'(b.buf_wr_en),    0);
        check({tag, "_buf_col"},      32'(b.buf_col),      0);
        check({tag, "_buf_row"},      32'(b.buf_row),      0);
        check({tag, "_buf_valid"},    32'(b.buf_valid),    0);
        check({tag, "_in_row2_cond"}, 32'(b.in_row2_cond), 0);
        check({tag, "_busy"},         32'(busy),           0);
        check({tag, "_frame_done"},   32'(frame_done),     0);
    endtask

    // mode 0: stream, 1: pix_valid toggled, 2: stall at (5,10) + start in RUN,
    // 3: reset at (5,7). Entered and left at posedge+#1.
    task automatic run_frame(input int mode);
        int guard = 0;
        bit ph = 1'b1;
        f_wr = 0; f_win = 0; f_done = 0; f_dup = 0;
        f_done_cyc = 0; f_lastwin_cyc = 0;
        start = 1'b1; b.pix_valid = 1'b1; b.win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (f_done == 0 && guard < 4000) begin
            guard++;
            b.win_ready = 1'b1;
            b.pix_valid = (mode == 1) ? ph : 1'b1;
            ph = !ph;
            start = (mode == 2) && m_active && (m_idx == 3 * W);
            if (mode == 2 && m_pend && m_idx == 5 * W + 10) begin
                for (int i = 0; i < 5; i++) begin
                    b.win_ready = 1'b0;
                    @(negedge clk);
                    check("stall_pix_ready", 32'(b.pix_ready), 0);
                    check("stall_buf_col",   32'(b.buf_col),   10);
                    check("stall_buf_valid", 32'(b.buf_valid), 1);
                    @(posedge clk); #1;
                end
                b.win_ready = 1'b1;
                @(negedge clk);
                check("resume_pix_ready", 32'(b.pix_ready), 1);
                @(posedge clk); #1;
                @(negedge clk);
                check("resume_buf_col", 32'(b.buf_col), 11);
            end else if (mode == 3 && m_pend && m_idx == 5 * W + 7) begin
                rstb = 1'b0;
                @(negedge clk);
                check_reset_vals("midreset");
                @(posedge clk); #1;
                rstb = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        check("frame_timeout", 32'(f_done != 0), 1);
    endtask

    task automatic frame_checks();
        check("frame_wr_pulses",   f_wr,  TOT);
        check("frame_windows",     f_win, (W - K + 1) * (H - K + 1));
        check("frame_done_pulses", f_done, 1);
        check("done_after_last",   f_done_cyc - f_lastwin_cyc, 1);
        check("first_win_row",     f_win_r0, 2);
        check("first_win_col",     f_win_c0, 2);
        check("first_wr_row",      f_wr_r0, 0);
        check("first_wr_col",      f_wr_c0, 0);
        check("dup_wr",            f_dup, 0);
        check("busy_after_frame",  32'(busy), 0);
`ifdef WSC_WIN_CNT_EN
        check("win_cnt_final",     32'(win_cnt), 900);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_r[4];
        int exp_c[4];
        int guard;
        exp_r = '{2, 2, 3, 3};
        exp_c = '{2, 3, 2, 3};
        rstb = 1'b0; start = 1'b0; s_start = 1'b0;
        b.pix_valid = 1'b0; b.win_ready = 1'b1;
        sb.pix_valid = 1'b0; sb.win_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rstb = 1'b1;
        @(posedge clk); #1;

        run_frame(0); frame_checks();
        run_frame(2); frame_checks();
        run_frame(1); frame_checks();
        run_frame(3);
        run_frame(0); frame_checks();

        b.pix_valid = 1'b0;
        s_start = 1'b1; sb.pix_valid = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        guard = 0;
        while (s_done == 0 && guard < 200) begin
            guard++;
            @(posedge clk); #1;
        end
        check("s_frame_timeout", 32'(s_done != 0), 1);
        check("s_wr_pulses", s_wr, 16);
        check("s_windows",   s_nw, 4);
        for (int i = 0; i < 4; i++) begin
            check("s_win_row", s_r[i], exp_r[i]);
            check("s_win_col", s_c[i], exp_c[i]);
        end
        check("s_done_gap", s_done_cyc - s_last_cyc, 2);
        check("s_busy_after", 32'(s_busy), 0);
`ifdef WSC_WIN_CNT_EN
        check("s_win_cnt", 32'(s_win_cnt), 4);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
